v_usb_test: RTL and testbench
=============================

Name: v_usb_test

Overview:
Small transmit-handshake test block with three parts:
- a three-state control FSM (IDLE/CRC1/CRC2) that drives tx_valid from send_data, tx_ready and a 10-bit cycle counter;
- a 10-bit shift register that records the tx_valid history;
- a registered 1-bit + 1-bit adder.

It is a self-contained test vehicle for handshake and arithmetic generation flows, instantiated directly by a bench with no surrounding logic.

Parameters:
None. All widths are fixed: counter 10 bits, buff 10 bits, sum 2 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
send_data  input  1  request to start a transfer (sampled in IDLE)
tx_ready  input  1  downstream ready
a  input  1  adder operand
b  input  1  adder operand
tx_valid  output  1  combinational valid, decoded from current state
buff  output  10  tx_valid history shift register; buff[0] is the newest sample
sum  output  2  registered a+b

Behaviour:
Clocking and reset
- One clock domain: clk.
- Reset is asynchronous and active-low. While reset=0: state=IDLE, counter=0, buff=0, sum=0, independent of clk.
- Reset asserted mid-operation aborts immediately to these values.

State encoding
- IDLE=3'b000, CRC1=3'b001, CRC2=3'b011.
- Any other code is illegal: tx_valid=0, counter holds, next state=IDLE.

tx_valid (combinational from state)
- IDLE: 1. CRC1: 1. CRC2: 0. Illegal code: 0.
- tx_valid=1 during reset, because the state is IDLE.

Counter (10-bit, internal)
- Default each cycle: in IDLE, CRC1 and CRC2 the counter increments by 1, wrapping 1023 -> 0.
- Exception: the CRC2 -> IDLE transition loads 0.

Transitions (evaluated each rising edge, reset deasserted)
- IDLE: send_data=1 -> CRC1; otherwise stay.
- CRC1: tx_ready=0 -> CRC2; otherwise stay.
- CRC2, tx_ready=1: counter<9 -> CRC1; counter>=9 -> stay in CRC2 (counter keeps incrementing).
- CRC2, tx_ready=0: counter==10 -> IDLE and counter<=0; otherwise stay.
- Comparisons use the registered (current) counter value.

buff
- Each edge: buff <= {buff[8:0], tx_valid}.
- One-cycle latency from tx_valid to buff[0].
- buff[9] is tx_valid from 10 cycles earlier.

sum
- Each edge: sum <= a + b, zero-extended to 2 bits.
- One-cycle latency; a=b=1 gives 2'b10.

Other rules
- No other outputs.
- Inputs are assumed synchronous to clk; no input synchronisers are included.

Test Plan:
- Reset: drive a=b=1 and run several cycles, then pull reset=0 between edges. Required: buff=0 and sum=0 immediately, before the next edge; tx_valid=1.
- Adder: from reset, apply (a,b)=(0,0),(1,0),(0,1),(1,1) on successive edges. Required: sum=0,1,1,2, each one edge later.
- buff fill: release reset with send_data=0. Required: buff=0x001, 0x003, 0x007, ... 0x3FF after the 10th edge, then stays 0x3FF.
- Full handshake: release reset with send_data=1, tx_ready=1.
  - Edge 1: CRC1, counter=1.
  - Drop tx_ready at counter=3: next edge CRC2, counter=4, tx_valid=0.
  - Raise tx_ready: next edge CRC1, counter=5.
  - Drop tx_ready: edges give CRC2 at counter 6,7,8,9,10, then IDLE with counter=0 and tx_valid=1.
  - buff shows the matching 0 bits.
- CRC2 stall: enter CRC2 with counter>=9 and hold tx_ready=1. Required: state stays CRC2, tx_valid=0 every cycle, counter increments.
- Wrap: hold IDLE with send_data=0 for 1024 edges. Required: counter returns to 0, tx_valid stays 1.

Source files
------------

// File: rtl/v_usb_test.sv
// Transmit-handshake test vehicle: IDLE/CRC1/CRC2 control FSM driving tx_valid,
// a 10-deep tx_valid history register and a registered 1-bit + 1-bit adder.
module v_usb_test (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_data,
  input  logic       tx_ready,
  input  logic       a,
  input  logic       b,
  output logic       tx_valid,
  output logic [9:0] buff,
  output logic [1:0] sum
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CRC1 = 3'b001,
    CRC2 = 3'b011
  } state_t;

  state_t     state;
  logic [9:0] counter;

  // Valid is asserted in IDLE as well, so it reads 1 while reset is held.
  assign tx_valid = (state == IDLE) || (state == CRC1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= counter + 10'd1;
          if (send_data) state <= CRC1;
        end
        CRC1: begin
          counter <= counter + 10'd1;
          if (!tx_ready) state <= CRC2;
        end
        CRC2: begin
          if (tx_ready) begin
            // Late in the count the FSM parks in CRC2 even when ready returns.
            counter <= counter + 10'd1;
            if (counter < 10'd9) state <= CRC1;
          end else if (counter == 10'd10) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buff <= '0;
      sum  <= '0;
    end else begin
      buff <= {buff[8:0], tx_valid};
      sum  <= {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: tb/tb_v_usb_test.sv
// Randomized bench for v_usb_test against a cycle-level behavioural model
// (mode/count integers plus a tx_valid history queue).
module tb_v_usb_test;

  logic       clk;
  logic       reset;
  logic       send_data;
  logic       tx_ready;
  logic       a;
  logic       b;
  logic       tx_valid;
  logic [9:0] buff;
  logic [1:0] sum;

  int checks;
  int errors;

  // Model: mode 0 = idle, 1 = first crc phase, 2 = second crc phase
  int   m_mode;
  int   m_cnt;
  int   m_sum;
  bit   hist[$];

  v_usb_test dut (
    .clk      (clk),
    .reset    (reset),
    .send_data(send_data),
    .tx_ready (tx_ready),
    .a        (a),
    .b        (b),
    .tx_valid (tx_valid),
    .buff     (buff),
    .sum      (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int model_buff();
    int v = 0;
    for (int i = 0; i < 10; i++) begin
      int idx = hist.size() - 1 - i;
      if (idx >= 0 && hist[idx]) v |= (1 << i);
    end
    return v;
  endfunction

  function automatic int model_valid();
    return (m_mode != 2) ? 1 : 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".tx_valid"}, int'(tx_valid), model_valid());
    check({tag, ".buff"}, int'(buff), model_buff());
    check({tag, ".sum"}, int'(sum), m_sum);
    check({tag, ".counter"}, int'(dut.counter), m_cnt);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_sum  = 0;
    hist.delete();
  endtask

  // One rising edge: advance model with the inputs present before the edge.
  task automatic step(input string tag);
    if (reset) begin
      hist.push_back(model_valid() != 0);
      if (hist.size() > 10) void'(hist.pop_front());
      m_sum = int'(a) + int'(b);
      case (m_mode)
        0: begin
          m_cnt = (m_cnt + 1) % 1024;
          if (send_data) m_mode = 1;
        end
        1: begin
          m_cnt = (m_cnt + 1) % 1024;
          if (!tx_ready) m_mode = 2;
        end
        default: begin
          if (tx_ready) begin
            if (m_cnt < 9) m_mode = 1;
            m_cnt = (m_cnt + 1) % 1024;
          end else if (m_cnt == 10) begin
            m_mode = 0;
            m_cnt  = 0;
          end else begin
            m_cnt = (m_cnt + 1) % 1024;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Assert reset between edges, verify the asynchronous clear, release later.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_buff"}, int'(buff), 0);
    check({tag, ".rst_sum"}, int'(sum), 0);
    check({tag, ".rst_valid"}, int'(tx_valid), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    send_data = 1'b0;
    tx_ready  = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("init");
    @(negedge clk);
    reset = 1'b1;

    // Adder table
    a = 0; b = 0; step("add00");
    a = 1; b = 0; step("add10");
    a = 0; b = 1; step("add01");
    a = 1; b = 1; step("add11");
    check("add11_const", int'(sum), 2);

    // Mid-operation reset with a=b=1, then fill buff from idle
    for (int i = 0; i < 3; i++) step("pre_rst");
    apply_reset("midrst");
    a = 0; b = 0;
    for (int i = 0; i < 12; i++) step("fill");
    check("fill_full", int'(buff), 10'h3FF);

    // Full handshake
    apply_reset("hs");
    send_data = 1; tx_ready = 1;
    step("hs_e1");
    send_data = 0;
    while (m_cnt != 3) step("hs_crc1");
    tx_ready = 0; step("hs_crc2a");
    check("hs_valid0", int'(tx_valid), 0);
    tx_ready = 1; step("hs_back");
    tx_ready = 0;
    for (int i = 0; i < 6; i++) step("hs_tail");
    check("hs_idle_cnt", int'(dut.counter), 0);
    check("hs_idle_valid", int'(tx_valid), 1);

    // CRC2 stall with counter >= 9 and ready held high
    apply_reset("stall");
    send_data = 1; tx_ready = 1;
    step("st_go");
    send_data = 0;
    while (m_cnt != 8) step("st_crc1");
    tx_ready = 0; step("st_enter");
    tx_ready = 1;
    for (int i = 0; i < 20; i++) step("st_hold");
    check("stall_valid", int'(tx_valid), 0);

    // Counter wrap in idle
    apply_reset("wrap");
    send_data = 0;
    for (int i = 0; i < 1024; i++) step("wrap");
    check("wrap_cnt", int'(dut.counter), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      send_data = 1'($urandom_range(0, 3) == 0);
      tx_ready  = 1'($urandom_range(0, 1));
      a         = 1'($urandom);
      b         = 1'($urandom);
      if ($urandom_range(0, 499) == 0) apply_reset("rnd_rst");
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
